capture_controller: RTL
=======================

# capture_controller

Sequences one acquisition of the logic analyzer. It arms on request and fills the circular sample RAM with a programmable number of pre-trigger samples. It then waits for a fresh rising edge on the channel-trigger run signal and records a programmable number of post-trigger samples. Afterwards it presents the capture for readout in chronological order. It sits between the channel trigger (`i_trig`), the sample-rate strobe and the sample RAM write/read address ports.

## Interface
- DEPTH, 256, sample RAM depth in samples; power of two, ≥ 4. Localparam AW = $clog2(DEPTH).
- i_clk  in  1  sole clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_arm  in  1  level; sampled high in IDLE or DONE starts a capture.
- i_abort  in  1  level; returns to IDLE from any state; has priority over i_arm.
- i_trig  in  1  trigger run level from channel trigger.
- i_sample_en  in  1  one-cycle sample strobe; each strobe while capturing is one RAM write.
- i_pretrig  in  AW  pre-trigger sample count P (0..DEPTH-1); latched on arm.
- i_posttrig  in  AW  post-trigger count field N; the capture takes N+1 post samples; latched on arm.
- i_rd_next  in  1  advance readout pointer (DONE only).
- o_wr_en  out  1  RAM write enable = i_sample_en while in PRE/ARMED/POST (combinational).
- o_wr_addr  out  AW  RAM write address (write pointer).
- o_rd_addr  out  AW  RAM read address = start address + read index (mod DEPTH).
- o_rd_last  out  1  read index equals last sample of capture.
- o_trig_addr  out  AW  address of first post-trigger sample.
- o_busy  out  1  state is PRE, ARMED or POST.
- o_triggered  out  1  state is POST or DONE.
- o_done  out  1  state is DONE.
- o_state  out  3  IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4.

## Operation
- Reset state:
  - State is IDLE; all registers and outputs are 0.
  - The i_trig history register resets to 0.
- Arm (IDLE/DONE, i_arm=1, i_abort=0):
  - Latch P.
  - Latch effective post count E = min(N, DEPTH-1-P). The total capture length is T = P+E+1 ≤ DEPTH.
  - Clear the write pointer, pre counter, post counter and read index.
  - Next state is PRE if P>0, else ARMED.
  - i_arm while busy is ignored.
- PRE:
  - Each strobe writes at the write pointer, then increments the pointer (wraps DEPTH-1→0) and the pre counter.
  - On the write that makes pre count = P, the next state is ARMED.
  - Trigger edges are ignored.
- ARMED:
  - Strobes keep writing circularly.
  - The trigger edge is trig_edge = i_trig & ~i_trig_q, where i_trig_q is registered every cycle in all states. A level already high on entry never fires.
  - On trig_edge: o_trig_addr ← current write pointer; start address ← write pointer − P (mod DEPTH); next state is POST.
  - A strobe in the edge cycle is written and counts as post sample 1.
- POST:
  - Each strobe writes and increments the post counter.
  - The write that brings the count to E+1 is the last one; the next state is DONE.
  - Further i_trig activity is ignored.
- DONE:
  - No writes.
  - i_rd_next increments the read index. From index T−1 it wraps to 0.
  - o_rd_last = (index == T−1).
  - o_trig_addr and the start address hold until the next arm.
- Abort:
  - i_abort=1 in any state goes to IDLE on the next edge.
  - o_wr_en is forced 0 in that same cycle.
  - Latched addresses are cleared.
- Counters are AW+1 bits wide where they must reach DEPTH. Address arithmetic is modulo DEPTH.

## Timing
- i_arm sampled at edge k: o_busy/o_state update at k+1. Strobes are first written when asserted in the cycle after k.
- o_wr_en and o_wr_addr are valid in the same cycle as i_sample_en.
- o_triggered rises one cycle after the edge cycle.
- o_done rises one cycle after the final post write.
- o_rd_addr updates one cycle after an i_rd_next pulse; o_rd_addr at DONE entry equals the start address.
- Simultaneous i_abort and i_arm: abort wins. In IDLE both → stay IDLE.
- A trigger edge in the same cycle as the PRE→ARMED transition write is ignored; only edges seen while the state is ARMED count.
- An asynchronous reset mid-capture returns immediately to IDLE with all outputs 0.

## Test plan
- Reset mid-POST: drop i_rst_n asynchronously → outputs are 0 immediately and o_state=0 without a clock edge.
- Basic capture, DEPTH=16, P=4, N=3, strobe every cycle, i_trig rises after 10 writes:
  - 4 PRE writes at addresses 0–3, then ARMED.
  - Trigger sets o_trig_addr=10 and start address 6.
  - 4 POST writes at 10–13, then o_done.
  - Readout of 8 samples gives addresses 6–13, with o_rd_last on address 13.
- Trigger during PRE: i_trig rises at write 2 and stays high (P=4) → no trigger. It only fires after i_trig falls and rises again while ARMED.
- Clamp and wrap, DEPTH=16, P=12, N=10:
  - E=3, T=16.
  - Trigger at write pointer 15 gives o_trig_addr=15 and start 3.
  - POST writes go to 15, 0, 1, 2.
  - Readout wraps 3…15, 0…2.
- P=0 with trigger edge and strobe in the same cycle: arm goes straight to ARMED. That write is post sample 1 and o_trig_addr equals that write address.
- Abort with arm, while ARMED: i_abort and i_arm both high → IDLE the next cycle, and o_wr_en=0 in the abort cycle even with i_sample_en=1.

Source files
------------

// File: rtl/capture_controller.sv
// capture_controller: sequences one logic-analyzer acquisition over a circular sample RAM.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_arm/i_abort start or cancel a capture;
// i_trig channel trigger level; i_sample_en sample strobe; i_pretrig/i_posttrig capture lengths;
// i_rd_next advances readout; o_wr_en/o_wr_addr RAM write port; o_rd_addr/o_rd_last readout;
// o_trig_addr first post-trigger address; o_busy/o_triggered/o_done/o_state status.
module capture_controller #(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_arm,
    input  logic          i_abort,
    input  logic          i_trig,
    input  logic          i_sample_en,
    input  logic [AW-1:0] i_pretrig,
    input  logic [AW-1:0] i_posttrig,
    input  logic          i_rd_next,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [AW-1:0] o_rd_addr,
    output logic          o_rd_last,
    output logic [AW-1:0] o_trig_addr,
    output logic          o_busy,
    output logic          o_triggered,
    output logic          o_done,
    output logic [2:0]    o_state
);
    typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, ARMED = 3'd2, POST = 3'd3, DONE = 3'd4} state_e;
    state_e        state_q, state_d;
    logic          trig_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, p_q, p_d, e_q, e_d, rd_idx_q, rd_idx_d;
    logic [AW-1:0] trig_addr_q, trig_addr_d, start_q, start_d, e_max;
    logic [AW:0]   pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
    logic          busy, trig_edge, wr, last;
    assign busy      = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
    assign trig_edge = i_trig & ~trig_q;
    assign wr        = busy & i_sample_en & ~i_abort;
    // P+E never exceeds DEPTH-1, so the AW-bit sum cannot overflow
    assign last      = rd_idx_q == p_q + e_q;
    // DEPTH-1-P is the bitwise complement because DEPTH is a power of two
    assign e_max     = ~i_pretrig;
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        p_d         = p_q;
        e_d         = e_q;
        rd_idx_d    = rd_idx_q;
        trig_addr_d = trig_addr_q;
        start_d     = start_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        if (i_abort) begin
            state_d     = IDLE;
            wr_ptr_d    = '0;
            p_d         = '0;
            e_d         = '0;
            rd_idx_d    = '0;
            trig_addr_d = '0;
            start_d     = '0;
            pre_cnt_d   = '0;
            post_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (i_arm) begin
                        state_d     = (i_pretrig != '0) ? PRE : ARMED;
                        p_d         = i_pretrig;
                        e_d         = (i_posttrig < e_max) ? i_posttrig : e_max;
                        wr_ptr_d    = '0;
                        rd_idx_d    = '0;
                        trig_addr_d = '0;
                        start_d     = '0;
                        pre_cnt_d   = '0;
                        post_cnt_d  = '0;
                    end else if (state_q == DONE && i_rd_next) begin
                        rd_idx_d = last ? '0 : rd_idx_q + 1'b1;
                    end
                end
                PRE: begin
                    if (i_sample_en) begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                        state_d   = (pre_cnt_d == {1'b0, p_q}) ? ARMED : PRE;
                    end
                end
                ARMED: begin
                    if (trig_edge) begin
                        trig_addr_d = wr_ptr_q;
                        start_d     = wr_ptr_q - p_q;
                        post_cnt_d  = {{AW{1'b0}}, i_sample_en};
                        // with E=0 the strobe in the edge cycle already completes the capture
                        state_d     = (i_sample_en && e_q == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (i_sample_en) begin
                        post_cnt_d = post_cnt_q + 1'b1;
                        state_d    = (post_cnt_d == {1'b0, e_q} + 1'b1) ? DONE : POST;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            trig_q      <= 1'b0;
            wr_ptr_q    <= '0;
            p_q         <= '0;
            e_q         <= '0;
            rd_idx_q    <= '0;
            trig_addr_q <= '0;
            start_q     <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            trig_q      <= i_trig;
            wr_ptr_q    <= wr_ptr_d;
            p_q         <= p_d;
            e_q         <= e_d;
            rd_idx_q    <= rd_idx_d;
            trig_addr_q <= trig_addr_d;
            start_q     <= start_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
        end
    end
    assign o_wr_en     = wr;
    assign o_wr_addr   = wr_ptr_q;
    assign o_rd_addr   = start_q + rd_idx_q;
    assign o_rd_last   = (state_q == DONE) & last;
    assign o_trig_addr = trig_addr_q;
    assign o_busy      = busy;
    assign o_triggered = (state_q == POST) || (state_q == DONE);
    assign o_done      = state_q == DONE;
    assign o_state     = state_q;
endmodule
